// File: rtl/neuroset_host_loader.sv
// Host-side loader for the neuroset classifier: streams one image into the
// classifier database, pulses GO, waits for STOP and returns the class.
module neuroset_host_loader #(
    parameter int SIZE_1         = 11,
    parameter int ADDR_W         = 13,
    parameter int BASE_ADDR      = 0,
    parameter int LOAD_WORDS     = 784,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [SIZE_1-1:0] in_data,
    output logic                     in_ready,
    output logic                     we_database,
    output logic signed [SIZE_1-1:0] dp_database,
    output logic [ADDR_W-1:0]        address_p_database,
    output logic                     GO,
    input  logic                     STOP,
    input  logic [3:0]               RESULT,
    output logic                     busy,
    output logic                     res_valid,
    output logic [3:0]               res_data,
    input  logic                     res_ready,
    output logic                     timeout
);
    localparam int CNT_W = $clog2(LOAD_WORDS) + 1;
    localparam int RUN_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_WORDS - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, GAP, PULSE, ARM, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RUN_W-1:0] run_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            run_cnt            <= '0;
            in_ready           <= 1'b0;
            we_database        <= 1'b0;
            dp_database        <= '0;
            address_p_database <= '0;
            GO                 <= 1'b0;
            busy               <= 1'b0;
            res_valid          <= 1'b0;
            res_data           <= '0;
            timeout            <= 1'b0;
        end else begin
            we_database <= 1'b0;
            GO          <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= LOAD;
                    cnt      <= '0;
                    timeout  <= 1'b0;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                end
                LOAD: if (in_valid) begin
                    we_database        <= 1'b1;
                    dp_database        <= in_data;
                    address_p_database <= ADDR_W'(BASE_ADDR) + ADDR_W'(cnt);
                    cnt                <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        in_ready <= 1'b0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    GO    <= 1'b1;
                    state <= PULSE;
                end
                PULSE: begin
                    run_cnt <= '0;
                    state   <= ARM;
                end
                // STOP still high here is left over from a previous run, so
                // only the timeout can end ARM besides STOP going low.
                ARM: begin
                    run_cnt <= run_cnt + RUN_W'(1);
                    if (run_cnt == RUN_LAST) begin
                        res_data  <= 4'hF;
                        res_valid <= 1'b1;
                        timeout   <= 1'b1;
                        state     <= DONE;
                    end else if (!STOP) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    run_cnt <= run_cnt + RUN_W'(1);
                    if (STOP) begin
                        res_data  <= RESULT;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else if (run_cnt == RUN_LAST) begin
                        res_data  <= 4'hF;
                        res_valid <= 1'b1;
                        timeout   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuroset_host_loader.sv
// Scoreboard bench for neuroset_host_loader: driver pushes expected writes,
// GO pulses and results; a negedge monitor pops and compares them.
module tb_neuroset_host_loader;
    localparam int SIZE_1     = 11;
    localparam int ADDR_W     = 13;
    localparam int BASE_ADDR  = 0;
    localparam int LOAD_WORDS = 784;
    localparam int TO         = 1024;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic              STOP = 1'b0, res_ready = 1'b0;
    logic [SIZE_1-1:0] in_data = '0;
    logic [3:0]        RESULT = '0;
    logic              in_ready, we_database, GO, busy, res_valid, timeout;
    logic [SIZE_1-1:0] dp_database;
    logic [ADDR_W-1:0] address_p_database;
    logic [3:0]        res_data;

    neuroset_host_loader #(
        .SIZE_1(SIZE_1), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR),
        .LOAD_WORDS(LOAD_WORDS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .we_database(we_database),
        .dp_database(dp_database), .address_p_database(address_p_database),
        .GO(GO), .STOP(STOP), .RESULT(RESULT), .busy(busy),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [ADDR_W-1:0] a; logic [SIZE_1-1:0] d; int c;} wr_t;
    typedef struct {logic [3:0] d; logic to; int c;} res_t;

    wr_t  exp_wr[$];
    int   exp_go[$];
    res_t exp_res[$];
    int   n_chk = 0, n_fail = 0, n_writes = 0;
    int   first_c, last_c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string got, input string want);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %s expected %s", nm, got, want);
    endtask

    // Monitor: every observable event must match the head of its queue.
    logic rv_q = 1'b0;
    always @(negedge clk) begin
        wr_t w;
        if (!rst_n) begin
            rv_q = 1'b0;
        end else begin
            if (we_database) begin
                if (exp_wr.size() == 0) fail("write_expected", "write strobe", "no write");
                else begin
                    w = exp_wr.pop_front();
                    chk("write_addr", 32'(address_p_database), 32'(w.a));
                    chk("write_data", 32'(dp_database), 32'(w.d));
                    chk("write_cycle", cyc, w.c);
                    n_writes++;
                end
            end
            if (GO) begin
                if (exp_go.size() == 0) fail("go_expected", "GO high", "GO low");
                else chk("go_cycle", cyc, exp_go.pop_front());
            end
            if (res_valid) begin
                if (exp_res.size() == 0) fail("result_expected", "res_valid high", "res_valid low");
                else begin
                    if (!rv_q) chk("res_first_cycle", cyc, exp_res[0].c);
                    chk("res_data", 32'(res_data), 32'(exp_res[0].d));
                    if (res_ready) begin
                        chk("timeout_flag", 32'(timeout), 32'(exp_res[0].to));
                        void'(exp_res.pop_front());
                    end
                end
            end
            rv_q = res_valid;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_we"}, 32'(we_database), 0);
        chk({tag, "_dp"}, 32'(dp_database), 0);
        chk({tag, "_addr"}, 32'(address_p_database), 0);
        chk({tag, "_go"}, 32'(GO), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
        chk({tag, "_res_data"}, 32'(res_data), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("in_ready_after_start", 32'(in_ready), 1);
        chk("busy_after_start", 32'(busy), 1);
        chk("timeout_cleared", 32'(timeout), 0);
    endtask

    // Returns 1 if the load was cut short by a reset.
    task automatic load_image(input bit stall, input bit nominal, input int abort_at,
                              output bit aborted);
        int k = 0;
        int it = 0;
        bit v, acc;
        logic [SIZE_1-1:0] d;
        wr_t w;
        aborted = 1'b0;
        @(posedge clk); #1;
        while (k < LOAD_WORDS && it < 20000) begin
            it++;
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            d = nominal ? SIZE_1'(k - 392) : SIZE_1'($urandom);
            in_valid = v;
            in_data  = d;
            @(negedge clk);
            acc = v && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                w.a = ADDR_W'(BASE_ADDR + k);
                w.d = d;
                w.c = cyc;
                exp_wr.push_back(w);
                if (k == 0) first_c = cyc;
                last_c = cyc;
                k++;
                if (k == abort_at) begin
                    in_valid = 1'b0;
                    #2 rst_n = 1'b0;
                    #1 check_zero("mid_load_reset");
                    exp_wr.delete();
                    exp_go.delete();
                    exp_res.delete();
                    @(posedge clk); #1 rst_n = 1'b1;
                    start = 1'b0;
                    aborted = 1'b1;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (k != LOAD_WORDS) fail("load_accepts", $sformatf("%0d", k), $sformatf("%0d", LOAD_WORDS));
        else exp_go.push_back(last_c + 1);
    endtask

    task automatic wait_go(output int g);
        bit got = 1'b0;
        g = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (GO) begin got = 1'b1; g = cyc; break; end
        end
        if (!got) fail("go_wait", "no GO", "GO pulse");
    endtask

    task automatic push_res(input logic [3:0] d, input logic to, input int c);
        res_t r;
        r.d = d; r.to = to; r.c = c;
        exp_res.push_back(r);
    endtask

    task automatic finish_result(input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (res_valid) begin got = 1'b1; break; end
        end
        if (!got) fail("result_wait", "no res_valid", "res_valid");
        repeat (10) begin
            @(negedge clk);
            chk("res_valid_held", 32'(res_valid), 1);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
        @(negedge clk);
        chk("busy_after_ack", 32'(busy), 0);
        chk("res_valid_after_ack", 32'(res_valid), 0);
    endtask

    task automatic stop_after(input int dly, input logic [3:0] r);
        repeat (dly) @(posedge clk);
        #1;
        STOP   = 1'b1;
        RESULT = r;
        push_res(r, 1'b0, cyc + 1);
    endtask

    initial begin
        int g, w0;
        bit ab;
        logic [3:0] r;

        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Nominal back-to-back load, STOP 500 cycles after GO with class 7
        w0 = n_writes;
        do_start();
        load_image(1'b0, 1'b1, 0, ab);
        chk("nominal_back_to_back", last_c - first_c, LOAD_WORDS - 1);
        wait_go(g);
        stop_after(500, 4'd7);
        finish_result(50);
        STOP = 1'b0;
        chk("nominal_write_count", n_writes - w0, LOAD_WORDS);

        // Stalled stream with start held high (must be ignored outside IDLE)
        w0 = n_writes;
        do_start();
        start = 1'b1;
        load_image(1'b1, 1'b0, 0, ab);
        wait_go(g);
        r = 4'($urandom_range(0, 9));
        stop_after($urandom_range(5, 300), r);
        finish_result(50);
        STOP = 1'b0;
        chk("stall_write_count", n_writes - w0, LOAD_WORDS);

        // Stale STOP held through PULSE
        STOP = 1'b1;
        do_start();
        load_image(1'b0, 1'b0, 0, ab);
        wait_go(g);
        repeat (3) @(posedge clk);
        #1 STOP = 1'b0;
        r = 4'($urandom_range(0, 9));
        stop_after(100, r);
        finish_result(50);
        STOP = 1'b0;

        // Timeout: STOP never rises
        do_start();
        load_image(1'b1, 1'b0, 0, ab);
        wait_go(g);
        push_res(4'hF, 1'b1, g + 1 + TO);
        finish_result(TO + 50);
        chk("timeout_sticky_in_idle", 32'(timeout), 1);

        // Reset after word 300, then a fresh load from BASE_ADDR
        do_start();
        load_image(1'b0, 1'b0, 300, ab);
        chk("reset_aborted_load", 32'(ab), 1);
        @(negedge clk);
        check_zero("after_reset");
        w0 = n_writes;
        do_start();
        load_image(1'b1, 1'b0, 0, ab);
        wait_go(g);
        r = 4'($urandom_range(0, 9));
        stop_after($urandom_range(2, 40), r);
        finish_result(50);
        STOP = 1'b0;
        chk("reload_write_count", n_writes - w0, LOAD_WORDS);

        repeat (5) @(negedge clk);
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_go", exp_go.size(), 0);
        chk("pending_results", exp_res.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
